msk_rnd_source: RTL and testbench
=================================

# msk_rnd_source

Masked-gadget randomness source. A 127-bit LFSR PRNG that is seeded over a 32-bit handshake port, then warmed up, then supplies `n_rnd(d)` fresh bits per transfer over a valid/ready port. It feeds the `rnd` inputs of the SNI refresh gadgets and related MSK gadgets; it is the producer end of their randomness interface.

## Interface
- `d`, default 2: masking order the consumer is built for; legal range 2..5.
- `RND_W`, default `n_rnd(d)`: output width. Derived: d=2→1, d=3→2, d=4→4, d=5→5. Never overridden.
- `WARM_CYC`, default 128: number of warm-up advance cycles after seeding; 0 is legal.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `seed_in` input 32: seed word.
- `seed_valid` input 1: seed word present.
- `seed_ready` output 1: block accepts seed words; high only in SEED.
- `reseed` input 1: one-cycle request to restart seeding; sampled only in RUN.
- `rnd` output RND_W: current random word, registered.
- `rnd_valid` output 1: `rnd` is valid; high only in RUN.
- `rnd_ready` input 1: consumer takes `rnd`.

## Operation
- LFSR sequence a_n with a_{n+127} = a_{n+1} ^ a_n (x^127+x+1). State bit s[i] = a_{n+i}.
- One step outputs s[0], computes fb = s[1]^s[0], and sets s ← {fb, s[126:1]}. One advance = RND_W steps in a single cycle.
- Output word mapping: rnd[i] = a_{n+i} for the word starting at index n.
- States: SEED, WARM, RUN. Reset state is SEED.
- SEED:
  - A beat is accepted when seed_valid & seed_ready.
  - Beat k (0..3) loads s[32k+31:32k]. Beat 3 uses seed_in[30:0] only; seed_in[31] is ignored.
  - After beat 3: if the loaded state is all zero, force s[0]=1. Then go to WARM, or straight to RUN if WARM_CYC=0.
- WARM: one advance per cycle for WARM_CYC cycles, with no output. Then go to RUN.
- RUN entry: `rnd` is loaded with the next word in the same edge that enters RUN, and the LFSR advances past that word.
- RUN: on rnd_valid & rnd_ready, `rnd` loads the next word and the LFSR advances. Otherwise `rnd` and the state hold, so the consumer sees stable data under backpressure.
- Reseed: reseed=1 in RUN moves to SEED at the next edge.
  - The LFSR state is cleared to 0 and the beat counter to 0.
  - A transfer in the same cycle still completes; that word counts as consumed.
- seed_valid outside SEED and reseed outside RUN are ignored.
- Counters: beat_cnt 2 bits; warm_cnt of width clog2(WARM_CYC+1), min 1. Both clear on state entry.

## Timing
- Reset values: rnd=0, rnd_valid=0, LFSR=0, beat_cnt=0, warm_cnt=0, state=SEED. seed_ready=1 while rst is low after reset.
- seed_ready and rnd_valid are decoded directly from the state register; they have no combinational path from inputs.
- Seed accept to first valid word: the 4th beat's edge plus WARM_CYC edges. With WARM_CYC=0, rnd_valid rises the cycle after beat 3.
- Throughput: one word per cycle in RUN with rnd_ready held high.
- Reseed: rnd_valid drops and seed_ready rises the cycle after reseed is sampled.
- Reset mid-operation (any state): immediate return to reset values. Partially loaded seed beats are discarded.

## Structure
- Package `msk_rnd_pkg` holds:
  - function `n_rnd(d)`, shared with the refresh gadgets;
  - `LFSR_LEN`=127;
  - `SEED_W`=32;
  - `SEED_BEATS`=4;
  - the state encoding SEED/WARM/RUN.
- Sub-module `lfsr127_adv` (combinational):
  - parameter K;
  - input state[126:0];
  - outputs next_state[126:0] and bits[K-1:0], produced by K unrolled steps.
- The top level instantiates `lfsr127_adv` once with K=RND_W and shares it between WARM and RUN.

## Test plan
- Known seed, d=4, WARM_CYC=0: seed words 0x00000001,0,0,0. First rnd must be 4'b0001 (rnd[0]=1); second word 4'b0000. Continue checking against a software model of a_n.
- All-zero seed, d=4, WARM_CYC=0: seed 0,0,0,0. Output must be identical to the known-seed scenario (s[0] forced to 1).
- Backpressure, d=3: hold rnd_ready=0 for 10 cycles in RUN. rnd must stay constant. On release, consecutive words must match the model with no word skipped.
- Reset mid-seed: accept 2 beats, pulse rst, then send 4 fresh beats. Output must equal a clean run seeded with only the fresh beats. seed_ready must be 1 after reset.
- Reseed with simultaneous transfer: reseed=1 and rnd_ready=1 in the same cycle. The word is consumed and rnd_valid=0 next cycle. A new seed 0xDEADBEEF,0x01234567,0x89ABCDEF,0x7FFFFFFF with WARM_CYC=128 must yield the first word after exactly 128 WARM cycles, matching the model.
- Long run, d=5: 10000 transfers under random rnd_ready. Every word must match the model and rnd_valid must never drop in RUN.

Source files
------------

// File: rtl/msk_rnd_source_pkg.sv
// Shared definitions for the masked-gadget randomness source and the gadgets
// that consume its output.
package msk_rnd_pkg;

    localparam int LFSR_LEN   = 127;
    localparam int SEED_W     = 32;
    localparam int SEED_BEATS = 4;

    // SEED collects the 127-bit state, WARM discards early output, RUN serves words.
    typedef enum logic [1:0] {
        SEED = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } rnd_state_e;

    // Fresh random bits one refresh gadget of masking order d consumes per use.
    function automatic int n_rnd(input int d);
        case (d)
            2:       return 1;
            3:       return 2;
            4:       return 4;
            5:       return 5;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/msk_rnd_source_if.sv
// Seed input port and random-word output port of msk_rnd_source, bundled.
// The master side is the randomness source itself; the slave side is the
// seeding agent plus the randomness consumer.
interface msk_rnd_source_if #(
    parameter int RND_W = 1
);
    import msk_rnd_pkg::*;

    logic [SEED_W-1:0] seed_in;
    logic              seed_valid;
    logic              seed_ready;
    logic              reseed;
    logic [RND_W-1:0]  rnd;
    logic              rnd_valid;
    logic              rnd_ready;

    modport master (
        input  seed_in,
        input  seed_valid,
        input  reseed,
        input  rnd_ready,
        output seed_ready,
        output rnd,
        output rnd_valid
    );

    modport slave (
        output seed_in,
        output seed_valid,
        output reseed,
        output rnd_ready,
        input  seed_ready,
        input  rnd,
        input  rnd_valid
    );

endinterface

// File: rtl/msk_rnd_source_lfsr127_adv.sv
// Combinational K-step advance of the x^127+x+1 Fibonacci LFSR.
// Each step emits s[0] and shifts in s[1]^s[0] at the top, so bits[i] is the
// i-th sequence bit starting at the current state.
module lfsr127_adv
    import msk_rnd_pkg::*;
#(
    parameter int K = 1
) (
    input  logic [LFSR_LEN-1:0] state,
    output logic [LFSR_LEN-1:0] next_state,
    output logic [K-1:0]        bits
);

    logic [LFSR_LEN-1:0] s;

    // Unroll K single-bit steps of the recurrence a[n+127] = a[n+1] ^ a[n].
    always_comb begin
        s    = state;
        bits = '0;
        for (int k = 0; k < K; k++) begin
            bits[k] = s[0];
            s       = {s[1] ^ s[0], s[LFSR_LEN-1:1]};
        end
        next_state = s;
    end

endmodule

// File: rtl/msk_rnd_source.sv
// Randomness source for the SNI refresh and related MSK gadgets: a 127-bit
// LFSR seeded with four 32-bit beats, warmed up, then serving RND_W fresh
// bits per valid/ready transfer.
module msk_rnd_source
    import msk_rnd_pkg::*;
#(
    parameter int d        = 2,
    parameter int RND_W    = n_rnd(d),
    parameter int WARM_CYC = 128
) (
    input  logic               clk,
    input  logic               rst,
    msk_rnd_source_if.master   bus
);

    localparam int WARM_W = ($clog2(WARM_CYC + 1) < 1) ? 1 : $clog2(WARM_CYC + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARM_CYC > 0) ? WARM_CYC - 1 : 0);
    localparam logic [1:0]        BEAT_LAST = 2'(SEED_BEATS - 1);

    rnd_state_e          state_q, state_d;
    logic [LFSR_LEN-1:0] lfsr_q, lfsr_d;
    logic [RND_W-1:0]    rnd_q, rnd_d;
    logic [1:0]          beatCnt_q, beatCnt_d;
    logic [WARM_W-1:0]   warmCnt_q, warmCnt_d;

    logic [LFSR_LEN-1:0] seeded;
    logic [LFSR_LEN-1:0] advIn;
    logic [LFSR_LEN-1:0] advNext;
    logic [RND_W-1:0]    advBits;

    // State as it will be once the final beat lands; bit 31 of that beat is
    // dropped and an all-zero state is nudged off the LFSR's lock-up point.
    always_comb begin
        seeded = {bus.seed_in[SEED_W-2:0], lfsr_q[3*SEED_W-1:0]};
        if (seeded == '0) begin
            seeded[0] = 1'b1;
        end
    end

    // In SEED the advancer only matters on the final beat with no warm-up,
    // where the first word must come straight from the new seed.
    assign advIn = (state_q == SEED) ? seeded : lfsr_q;

    lfsr127_adv #(
        .K (RND_W)
    ) u_adv (
        .state      (advIn),
        .next_state (advNext),
        .bits       (advBits)
    );

    // Next-state logic for seeding, warm-up and word delivery. The last warm
    // cycle's advance is the one that produces the first output word.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        rnd_d     = rnd_q;
        beatCnt_d = beatCnt_q;
        warmCnt_d = warmCnt_q;
        case (state_q)
            SEED: begin
                if (bus.seed_valid) begin
                    beatCnt_d = beatCnt_q + 2'd1;
                    case (beatCnt_q)
                        2'd0: lfsr_d[1*SEED_W-1:0*SEED_W] = bus.seed_in;
                        2'd1: lfsr_d[2*SEED_W-1:1*SEED_W] = bus.seed_in;
                        2'd2: lfsr_d[3*SEED_W-1:2*SEED_W] = bus.seed_in;
                        default: begin
                            lfsr_d = seeded;
                        end
                    endcase
                    if (beatCnt_q == BEAT_LAST) begin
                        beatCnt_d = '0;
                        warmCnt_d = '0;
                        if (WARM_CYC == 0) begin
                            lfsr_d  = advNext;
                            rnd_d   = advBits;
                            state_d = RUN;
                        end else begin
                            state_d = WARM;
                        end
                    end
                end
            end
            WARM: begin
                lfsr_d    = advNext;
                warmCnt_d = warmCnt_q + 1'b1;
                if (warmCnt_q == WARM_LAST) begin
                    rnd_d     = advBits;
                    warmCnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (bus.rnd_ready) begin
                    rnd_d  = advBits;
                    lfsr_d = advNext;
                end
                if (bus.reseed) begin
                    lfsr_d    = '0;
                    beatCnt_d = '0;
                    state_d   = SEED;
                end
            end
            default: begin
                lfsr_d    = '0;
                beatCnt_d = '0;
                warmCnt_d = '0;
                state_d   = SEED;
            end
        endcase
    end

    // State, LFSR, counters and output word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEED;
            lfsr_q    <= '0;
            rnd_q     <= '0;
            beatCnt_q <= '0;
            warmCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            rnd_q     <= rnd_d;
            beatCnt_q <= beatCnt_d;
            warmCnt_q <= warmCnt_d;
        end
    end

    assign bus.seed_ready = (state_q == SEED);
    assign bus.rnd_valid  = (state_q == RUN);
    assign bus.rnd        = rnd_q;

endmodule

// File: tb/tb_msk_rnd_source.sv
// Testbench for msk_rnd_source. Three instances cover d=4 without warm-up,
// d=3 with 128 warm-up cycles and d=5 with a short warm-up; one is active at a
// time, selected by 'sel'. Expected words come from a bit-queue model of the
// x^127+x+1 sequence and flow through a scoreboard queue.
module tb_msk_rnd_source;

    logic        clk;
    logic        rst;
    int          sel;
    logic [31:0] seedIn;
    logic        seedValid;
    logic        reseed;
    logic        rndReady;

    int testsRun    = 0;
    int testsFailed = 0;

    bit          aq[$];
    logic [4:0]  sbq[$];

    msk_rnd_source_if #(.RND_W(4)) ifA ();
    msk_rnd_source_if #(.RND_W(2)) ifB ();
    msk_rnd_source_if #(.RND_W(5)) ifC ();

    msk_rnd_source #(.d(4), .WARM_CYC(0))   dutA (.clk(clk), .rst(rst), .bus(ifA.master));
    msk_rnd_source #(.d(3), .WARM_CYC(128)) dutB (.clk(clk), .rst(rst), .bus(ifB.master));
    msk_rnd_source #(.d(5), .WARM_CYC(4))   dutC (.clk(clk), .rst(rst), .bus(ifC.master));

    assign ifA.seed_in    = seedIn;
    assign ifA.seed_valid = seedValid && (sel == 0);
    assign ifA.reseed     = reseed && (sel == 0);
    assign ifA.rnd_ready  = rndReady && (sel == 0);
    assign ifB.seed_in    = seedIn;
    assign ifB.seed_valid = seedValid && (sel == 1);
    assign ifB.reseed     = reseed && (sel == 1);
    assign ifB.rnd_ready  = rndReady && (sel == 1);
    assign ifC.seed_in    = seedIn;
    assign ifC.seed_valid = seedValid && (sel == 2);
    assign ifC.reseed     = reseed && (sel == 2);
    assign ifC.rnd_ready  = rndReady && (sel == 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] curRnd();
        case (sel)
            0:       return 5'(ifA.rnd);
            1:       return 5'(ifB.rnd);
            default: return ifC.rnd;
        endcase
    endfunction

    function automatic logic curValid();
        case (sel)
            0:       return ifA.rnd_valid;
            1:       return ifB.rnd_valid;
            default: return ifC.rnd_valid;
        endcase
    endfunction

    function automatic logic curSeedReady();
        case (sel)
            0:       return ifA.seed_ready;
            1:       return ifB.seed_ready;
            default: return ifC.seed_ready;
        endcase
    endfunction

    function automatic int curW();
        case (sel)
            0:       return 4;
            1:       return 2;
            default: return 5;
        endcase
    endfunction

    function automatic int curWarm();
        case (sel)
            0:       return 0;
            1:       return 128;
            default: return 4;
        endcase
    endfunction

    // Load the sequence model: a[i] = state bit i, with the lock-up rescue.
    function automatic void modelSeed(input logic [31:0] w0, input logic [31:0] w1,
                                      input logic [31:0] w2, input logic [31:0] w3);
        logic [126:0] s;
        s = {w3[30:0], w2, w1, w0};
        if (s == '0) s[0] = 1'b1;
        aq.delete();
        for (int i = 0; i < 127; i++) aq.push_back(s[i]);
    endfunction

    // Next w sequence bits, oldest in bit 0.
    function automatic logic [4:0] modelWord(input int w);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            aq.push_back(aq[0] ^ aq[1]);
            r[i] = aq.pop_front();
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] s, input logic sv, input logic rs, input logic rr);
        seedIn    = s;
        seedValid = sv;
        reseed    = rs;
        rndReady  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetAll(input int newSel);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        sel = newSel;
        tick();
        rst = 1'b0;
        #1;
        sbq.delete();
        checkOutput("reset_rnd", 32'(curRnd()), 32'h0);
        checkOutput("reset_rnd_valid", 32'(curValid()), 32'h0);
        checkOutput("reset_seed_ready", 32'(curSeedReady()), 32'h1);
    endtask

    // One clock in RUN: a handshake retires the head word and queues the next.
    task automatic stepRun(input string tag);
        logic hs;
        hs = curValid() && rndReady;
        tick();
        if (hs) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
            sbq.push_back(modelWord(curW()));
        end
        if (curValid()) begin
            checkOutput(tag, 32'(curRnd()), (sbq.size() > 0) ? 32'(sbq[0]) : 32'hFFFF_FFFF);
        end
    endtask

    // Send four beats, then wait out warm-up and check its length and the first word.
    task automatic sendSeed(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] words [4];
        int          n;
        int          discard;
        words = '{w0, w1, w2, w3};
        for (int k = 0; k < 4; k++) begin
            checkOutput("seed_ready_beat", 32'(curSeedReady()), 32'h1);
            applyStimulus(words[k], 1'b1, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        modelSeed(w0, w1, w2, w3);
        discard = (curWarm() > 0) ? curWarm() - 1 : 0;
        for (int i = 0; i < discard; i++) void'(modelWord(curW()));
        sbq.delete();
        sbq.push_back(modelWord(curW()));
        n = 0;
        while (!curValid() && n < curWarm() + 10) begin
            tick();
            n++;
        end
        checkOutput("warm_len", 32'(n), 32'(curWarm()));
        checkOutput("first_word", 32'(curRnd()), 32'(sbq[0]));
    endtask

    initial begin
        logic [4:0] held;
        rst = 1'b1;
        sel = 0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);

        // Known seed, d=4, no warm-up.
        resetAll(0);
        sendSeed(32'h0000_0001, 32'h0, 32'h0, 32'h0);
        checkOutput("known_first_const", 32'(curRnd()), 32'h1);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        stepRun("known_run");
        checkOutput("known_second_const", 32'(curRnd()), 32'h0);
        for (int i = 0; i < 40; i++) stepRun("known_run");

        // All-zero seed must behave like the known seed.
        resetAll(0);
        sendSeed(32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("zero_first_const", 32'(curRnd()), 32'h1);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        stepRun("zero_run");
        checkOutput("zero_second_const", 32'(curRnd()), 32'h0);
        for (int i = 0; i < 40; i++) stepRun("zero_run");

        // Reset in the middle of seeding discards the partial beats.
        resetAll(0);
        applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(32'h1357_9BDF, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midseed_seed_ready", 32'(curSeedReady()), 32'h1);
        checkOutput("midseed_rnd_valid", 32'(curValid()), 32'h0);
        sendSeed(32'hCAFE_F00D, 32'h0BAD_C0DE, 32'h1234_5678, 32'h8765_4321);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) stepRun("midseed_run");

        // Backpressure on d=3 with seed_valid toggling, which RUN must ignore.
        resetAll(1);
        sendSeed(32'h0F0F_1234, 32'hA5A5_5A5A, 32'h0000_FFFF, 32'h4000_0001);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) stepRun("bp_pre");
        held = sbq[0];
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'hA5A5_A5A5, 1'(i % 2), 1'b0, 1'b0);
            stepRun("bp_hold");
            checkOutput("bp_hold_const", 32'(curRnd()), 32'(held));
            checkOutput("bp_valid", 32'(curValid()), 32'h1);
        end
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) stepRun("bp_release");

        // Reseed together with a transfer, then reseed with warm-up of 128.
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("reseed_rnd_valid", 32'(curValid()), 32'h0);
        checkOutput("reseed_seed_ready", 32'(curSeedReady()), 32'h1);
        sendSeed(32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h7FFF_FFFF);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) stepRun("reseed_run");

        // Long run on d=5 under random consumer readiness.
        resetAll(2);
        sendSeed($urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(32'h0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            stepRun("long_run");
            checkOutput("long_valid", 32'(curValid()), 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
